// File: rtl/pc_sequencer_if.sv
// Next-PC sequencer bus: decode/select inputs toward the sequencer, PC state back out.
interface pc_sequencer_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               stall;
    logic               halt_req;
    logic               branch_taken;
    logic               jump;
    logic               jump_reg;
    logic [31:0]        branch_offset;
    logic [31:0]        jump_target;
    logic [31:0]        jr_target;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               halted;
    logic [COUNT_W-1:0] retired_count;
    logic               trap;

    modport master (
        output stall, halt_req, branch_taken, jump, jump_reg,
        output branch_offset, jump_target, jr_target,
        input  pc, pc_plus4, halted, retired_count, trap
    );

    modport slave (
        input  stall, halt_req, branch_taken, jump, jump_reg,
        input  branch_offset, jump_target, jr_target,
        output pc, pc_plus4, halted, retired_count, trap
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC select for the single-cycle MIPS core.
// Optional macro PC_ALIGN_TRAP_EN: misaligned jump-register targets vector to TRAP_VECTOR.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned COUNT_W     = 32,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               trap_q, trap_d;

    logic [31:0]        pc_plus4_c;
    logic [31:0]        branch_pc;
    logic [31:0]        jump_pc;
    logic               jr_misaligned;

    // Candidate targets; carries out of bit 31 are discarded.
    assign pc_plus4_c = pc_q + 32'd4;
    assign branch_pc  = pc_plus4_c + {bus.branch_offset[29:0], 2'b00};
    assign jump_pc    = {pc_plus4_c[31:28], bus.jump_target[25:0], 2'b00};

`ifdef PC_ALIGN_TRAP_EN
    assign jr_misaligned = |bus.jr_target[1:0];
`else
    assign jr_misaligned = 1'b0;
    logic [31:0] unused_trap_vector;
    assign unused_trap_vector = TRAP_VECTOR;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.branch_offset[31:30], bus.jump_target[31:26]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            trap_q  <= trap_d;
        end
    end

    // Next-state and next-PC selection; stall and halt outrank every PC source.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        trap_d  = trap_q;

        case (state_q)
            ST_RUN: begin
                trap_d = 1'b0;
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else begin
                    count_d = count_q + COUNT_W'(1);
                    if (bus.jump_reg) begin
`ifdef PC_ALIGN_TRAP_EN
                        if (jr_misaligned) begin
                            pc_d   = TRAP_VECTOR;
                            trap_d = 1'b1;
                        end else begin
                            pc_d = bus.jr_target;
                        end
`else
                        pc_d = jr_misaligned ? bus.jr_target : bus.jr_target;
`endif
                    end else if (bus.jump) begin
                        pc_d = jump_pc;
                    end else if (bus.branch_taken) begin
                        pc_d = branch_pc;
                    end else begin
                        pc_d = pc_plus4_c;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4_c;
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.retired_count = count_q;
`ifdef PC_ALIGN_TRAP_EN
    assign bus.trap          = trap_q;
`else
    assign bus.trap          = 1'b0;
    logic unused_trap_q;
    assign unused_trap_q = trap_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cases plus randomized selects against a rule-level model.
module tb_pc_sequencer;

    localparam int unsigned COUNT_W     = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;
`ifdef PC_ALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    pc_sequencer #(
        .RESET_PC   (RESET_PC),
        .COUNT_W    (COUNT_W),
        .TRAP_VECTOR(TRAP_VECTOR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] count;
        logic        trap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] m_count;
    logic        m_trap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        m_count  = '0;
        m_trap   = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.halt_req      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jump          = 1'b0;
        bus.jump_reg      = 1'b0;
        bus.branch_offset = '0;
        bus.jump_target   = '0;
        bus.jr_target     = '0;
    endtask

    // Drive one cycle of selects at the negedge and queue the state expected after the next posedge.
    task automatic step(input logic s, input logic h, input logic br, input logic j, input logic jr,
                        input logic [31:0] off, input logic [31:0] jt, input logic [31:0] jrt);
        logic [31:0] seq;
        exp_t e;
        bus.stall         = s;
        bus.halt_req      = h;
        bus.branch_taken  = br;
        bus.jump          = j;
        bus.jump_reg      = jr;
        bus.branch_offset = off;
        bus.jump_target   = jt;
        bus.jr_target     = jrt;
        if (!m_halted) begin
            m_trap = 1'b0;
            if (s) begin
                m_pc = m_pc;
            end else if (h) begin
                m_halted = 1'b1;
            end else begin
                seq = m_pc + 32'd4;
                if (jr) begin
                    if (TRAP_EN && (jrt % 4) != 0) begin
                        m_pc   = TRAP_VECTOR;
                        m_trap = 1'b1;
                    end else begin
                        m_pc = jrt;
                    end
                end else if (j) begin
                    m_pc = (seq & 32'hF000_0000) | ((jt & 32'h03FF_FFFF) * 4);
                end else if (br) begin
                    m_pc = seq + off * 4;
                end else begin
                    m_pc = seq;
                end
                m_count = m_count + 32'd1;
            end
        end
        e.pc = m_pc; e.halted = m_halted; e.count = m_count; e.trap = m_trap;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic load_pc(input logic [31:0] target);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0, target);
    endtask

    // Async reset pulse inside the low clock phase; values must change before any edge.
    task automatic pulse_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        check("async_reset_pc", bus.pc, RESET_PC);
        check("async_reset_halted", 32'(bus.halted), 32'd0);
        check("async_reset_count", 32'(bus.retired_count), 32'd0);
        check("async_reset_trap", 32'(bus.trap), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: outputs settle after each posedge; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                check("halted", 32'(bus.halted), 32'(e.halted));
                check("retired_count", 32'(bus.retired_count), e.count);
                check("trap", 32'(bus.trap), 32'(e.trap));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] off, jrt;
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pc", bus.pc, RESET_PC);
        check("reset_halted", 32'(bus.halted), 32'd0);
        check("reset_count", 32'(bus.retired_count), 32'd0);
        check("reset_trap", 32'(bus.trap), 32'd0);
        reset = 1'b0;

        repeat (3) idle();

        load_pc(32'h0040_0010);
        step(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0000_0003, 32'h0, 32'h0);

        load_pc(32'h9000_0000);
        step(0, 0, 0, 1, 0, 32'h0, 32'h0000_0100, 32'h0);
        load_pc(32'h9000_0000);
        step(0, 0, 1, 1, 1, 32'h5, 32'h0000_0100, 32'h0000_2000);

        load_pc(32'hFFFF_FFFC);
        idle();

        load_pc(32'h0000_0040);
        repeat (2) step(1, 1, 0, 1, 0, 32'h0, 32'h0000_0123, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        repeat (10) step(0, 0, 0, 1, 0, 32'h0, 32'h0000_0123, 32'h0);
        pulse_reset();

        load_pc(32'h0000_1002);
        idle();
        load_pc(32'h0000_1003);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if (m_halted && ($urandom % 4) == 0) begin
                pulse_reset();
            end else begin
                off = ($urandom % 4 == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
                jrt = $urandom & 32'hFFFF_FFFC;
                if ($urandom % 4 == 0) jrt = jrt | 32'($urandom % 4);
                step(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 3) == 0,
                     ($urandom % 6) == 0, ($urandom % 8) == 0, off, $urandom, jrt);
            end
        end
        clear_inputs();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC sequencer for the 32-bit single-cycle MIPS core.
- Sits directly downstream of the 26-bit jump-address extender and consumes its 32-bit zero-extended output.
- Each cycle it selects one of four next-PC sources: sequential, branch, jump or jump-register. It supports stall and halt, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 32, width of the retired-instruction counter.
- TRAP_VECTOR, 32'h0000_0080, PC loaded on a misaligned jump-register target (used only with PC_ALIGN_TRAP_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC this cycle.
- halt_req  input  1  halt instruction decoded this cycle.
- branch_taken  input  1  conditional branch resolved taken.
- jump  input  1  J/JAL decoded.
- jump_reg  input  1  JR/JALR decoded.
- branch_offset  input  32  sign-extended 16-bit immediate, in words.
- jump_target  input  32  zero-extended jump address from the extender; bits [31:26] are ignored.
- jr_target  input  32  register-file rs value.
- pc  output  32  current PC, registered.
- pc_plus4  output  32  pc + 4, combinational.
- halted  output  1  core halted, registered.
- retired_count  output  COUNT_W  PC advances since reset, registered.
- trap  output  1  one-cycle misalignment pulse; tied to 0 without PC_ALIGN_TRAP_EN.

Behaviour:
- Reset is asynchronous, active-high. While asserted: pc = RESET_PC, halted = 0, retired_count = 0, trap = 0, state = RUN.
- States:
  - RUN: PC updates each clock per the rules below.
  - HALTED: PC, counter and all outputs frozen. Only reset exits HALTED.
- Update priority, evaluated at each rising edge while in RUN:
  1. stall = 1: pc holds, count holds, halt_req ignored.
  2. halt_req = 1: state goes to HALTED, halted = 1 from the next cycle, pc holds, count holds.
  3. jump_reg = 1: pc = jr_target.
  4. jump = 1: pc = {pc_plus4[31:28], jump_target[25:0], 2'b00}.
  5. branch_taken = 1: pc = pc_plus4 + {branch_offset[29:0], 2'b00}, modulo 2^32.
  6. Otherwise: pc = pc_plus4.
- Simultaneous select lines resolve strictly by the priority above; this is not treated as an error.
- retired_count increments by 1 on every edge where pc is updated by cases 3-6.
  - Wraps from all-ones to 0 silently.
- Arithmetic:
  - All PC arithmetic is 32-bit and discards the carry.
  - pc = 32'hFFFF_FFFC sequentially wraps to 32'h0000_0000.
- Latency: a new pc is visible one cycle after its select inputs are sampled. pc_plus4 follows pc combinationally.
- Reset asserted mid-operation, including while HALTED, forces reset values immediately, without waiting for a clock.
- jump_reg targets are not alignment-checked unless the feature below is enabled.

Optional Feature:
- Macro: PC_ALIGN_TRAP_EN.
- Defined:
  - A jump_reg update with jr_target[1:0] != 0 loads pc = TRAP_VECTOR.
  - trap pulses high for exactly the following cycle.
  - retired_count still increments.
  - stall and halt_req keep priority over the trap.
- Undefined:
  - jr_target is loaded verbatim, misaligned bits included.
  - trap is constant 0.

Test Plan:
- Reset release, no selects, 3 clocks -> pc 0x0, 0x4, 0x8, 0xC; retired_count = 3.
- pc = 0x0040_0010, branch_taken = 1, branch_offset = 0xFFFF_FFFC -> pc = 0x0040_0004; next cycle with branch_offset = 0x0000_0003 and branch_taken = 1 -> pc = 0x0040_0014.
- pc = 0x9000_0000, jump = 1, jump_target = 0x0000_0100 -> pc = 0x9000_0400. Same cycle adding jump_reg = 1 with jr_target = 0x0000_2000 -> pc = 0x0000_2000 (jump_reg wins).
- stall = 1 for 2 cycles with halt_req = 1 -> pc and count unchanged, halted = 0. Then stall = 0 with halt_req = 1 -> halted = 1, pc frozen for 10 cycles ignoring jump = 1.
- Async reset pulse mid-cycle while HALTED at pc = 0x0000_0040 -> pc = RESET_PC and halted = 0 before the next clock edge.
- With PC_ALIGN_TRAP_EN: jump_reg = 1, jr_target = 0x0000_1002 -> pc = 0x0000_0080, trap = 1 for one cycle. Without the macro, same stimulus -> pc = 0x0000_1002, trap = 0.
